// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, default widths
// and the response record returned on the rsp channel.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of the APB master bridge, bundled
// with a master modport (bridge side) and a slave modport (environment side).
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  // Handshake rule for cmd_* and rsp_*: a transfer happens on a rising PCLK
  // edge where valid and ready are both 1; once valid is raised, the payload
  // stays stable until that edge. APB itself follows PSEL/PENABLE/PREADY.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PDATA
  );

endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time through SETUP/ACCESS, result held on rsp.
// Define APB_MASTER_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus,
  output apb_mst_state_e      dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_mst_state_e    state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pdata_d   = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A completing PREADY wins over the timeout on the limit cycle.
        if (bus.PREADY) begin
          rsp_err_d   = bus.PSLVERR;
          rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PDATA     = pdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB RAM slave with programmable wait states,
// reference memory model with expected-response queue, randomized traffic.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int TO        = 16;
  localparam int RAM_WORDS = 32;

  logic           PCLK = 1'b0;
  logic           PRESETn;
  apb_mst_state_e dbg_state;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- APB RAM slave ----------------
  logic [DW-1:0] ram [RAM_WORDS];
  int slave_waits = 0;
  int wait_left   = 0;

  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (wait_left > 0) begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
        wait_left--;
      end else begin
        bus.PREADY = 1'b1;
        if (bus.PADDR < RAM_WORDS) begin
          bus.PSLVERR = 1'b0;
          if (bus.PWRITE) begin
            ram[bus.PADDR[4:0]] = bus.PDATA;
            bus.PRDATA = $urandom;
          end else begin
            bus.PRDATA = ram[bus.PADDR[4:0]];
          end
        end else begin
          bus.PSLVERR = 1'b1;
          bus.PRDATA  = $urandom;
        end
      end
    end else begin
      // outside ACCESS the response pins carry noise the bridge must ignore
      wait_left   = slave_waits;
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = $urandom;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [RAM_WORDS];
  logic [DW:0]   exp_q[$];

  function automatic apb_rsp_t ref_xfer(input logic wr, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d);
    apb_rsp_t r;
    r.err   = (a >= RAM_WORDS);
    r.rdata = '0;
    if (!r.err) begin
      if (wr) ref_mem[a[4:0]] = d;
      else    r.rdata = ref_mem[a[4:0]];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input int hold, input bit pend, input bit exp_to);
    apb_rsp_t    r;
    logic [DW:0] exp;
    int          acc;
    int          k;
    slave_waits = waits;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    check("cmd_ready_before_accept", bus.cmd_ready, 1);
    @(posedge PCLK);
    if (exp_to) begin
      r.rdata = '0;
      r.err   = 1'b1;
    end else begin
      r = ref_xfer(wr, a, d);
    end
    exp_q.push_back(r);
    acc = exp_to ? TO : waits + 1;
    #1;
    check("setup_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b10);
    check("setup_pwrite", bus.PWRITE, wr);
    check("setup_paddr", bus.PADDR, a);
    check("setup_pdata", bus.PDATA, d);
    check("setup_cmd_ready", bus.cmd_ready, 0);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    @(posedge PCLK); #1;
    check("access_entry", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b110);
    for (int i = 0; i < acc - 1; i++) begin
      @(posedge PCLK); #1;
      check("access_wait", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b110);
      check("access_paddr_stable", bus.PADDR, a);
    end
    @(posedge PCLK); #1;
    check("complete", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b001);
    exp = exp_q.pop_front();
    r   = apb_rsp_t'(exp);
    check("rsp_rdata", bus.rsp_rdata, r.rdata);
    check("rsp_err", bus.rsp_err, r.err);
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 7;
      end
      @(posedge PCLK); #1;
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_rdata", bus.rsp_rdata, r.rdata);
      check("hold_rsp_err", bus.rsp_err, r.err);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_psel", bus.PSEL, 0);
    end
    @(negedge PCLK);
    bus.rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    check("release_rsp_valid", bus.rsp_valid, 0);
    check("release_cmd_ready", bus.cmd_ready, 1);
    check("release_no_accept", bus.PSEL, 0);
    check("paddr_kept", bus.PADDR, a);
    check("pdata_kept", bus.PDATA, d);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic stall_then_reset(input int stall);
    int k;
    slave_waits = 100000;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 3;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    repeat (stall + 1) @(posedge PCLK);
    #1;
    check("stall_state_access", 64'(dbg_state), 64'(ACCESS));
    check("stall_apb", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b110);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_reset_apb", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b000);
    check("async_reset_state", 64'(dbg_state), 64'(IDLE));
    check("async_reset_paddr", bus.PADDR, 0);
    slave_waits = 0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (6) begin
      @(posedge PCLK); #1;
      check("post_reset_no_rsp", bus.rsp_valid, 0);
      check("post_reset_cmd_ready", bus.cmd_ready, 1);
    end
  endtask

  // ---------------- main sequence ----------------
  logic          t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  int            t_waits;
  int            t_hold;
  logic [DW-1:0] seed_v;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) begin
      seed_v     = $urandom;
      ram[i]     = seed_v;
      ref_mem[i] = seed_v;
    end
    PRESETn = 1'b1;
    #2;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_apb", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 3'b000);
    check("reset_paddr", bus.PADDR, 0);
    check("reset_pdata", bus.PDATA, 0);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b00);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;

    do_xfer(1'b1, 32'd5, 32'h0000_00A5, 0, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 32'd5, 32'h0,         3, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 32'd40, 32'h0,        0, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 32'd6, 32'h1234_5678, 1, 5, 1'b1, 1'b0);
    do_xfer(1'b0, 32'd6, 32'h0,         2, 2, 1'b0, 1'b0);
    do_xfer(1'b1, 32'd31, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 32'd32, 32'hCAFE_F00D, 0, 1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      t_wr    = 1'($urandom);
      t_addr  = $urandom_range(0, 47);
      t_data  = $urandom;
      t_waits = $urandom_range(0, 15);
      t_hold  = $urandom_range(0, 3);
      do_xfer(t_wr, t_addr, t_data, t_waits, t_hold, 1'($urandom), 1'b0);
    end

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    do_xfer(1'b0, 32'd5, 32'h0, 15, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 32'd9, 32'h0, 100000, 2, 1'b0, 1'b1);
    stall_then_reset(5);
`else
    stall_then_reset(100);
`endif

    do_xfer(1'b0, 32'd5, 32'h0, 1, 0, 1'b0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
